// File: rtl/bp_table_ctrl.sv
// 2-bit saturating-counter branch prediction table controller in front of a dual-port SRAM.
// Port 0 serves lookups (read-only); port 1 runs the init sweep and read-modify-write updates.
module bp_table_ctrl #(
  parameter int         INDEX_WIDTH = 8,
  parameter logic [1:0] INIT_CTR    = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   lkup_valid,
  output logic                   lkup_rdy,
  input  logic [31:0]            lkup_pc,

  output logic                   pred_valid,
  output logic                   pred_taken,
  output logic [1:0]             pred_ctr,

  input  logic                   upd_valid,
  output logic                   upd_rdy,
  input  logic [31:0]            upd_pc,
  input  logic                   upd_taken,

  output logic                   init_done,

  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [INDEX_WIDTH-1:0] sram_addr0,
  output logic [1:0]             sram_din0,
  input  logic [1:0]             sram_dout0,

  output logic                   sram_csb1,
  output logic                   sram_web1,
  output logic [INDEX_WIDTH-1:0] sram_addr1,
  output logic [1:0]             sram_din1,
  input  logic [1:0]             sram_dout1
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DRAIN,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_COMMIT
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = 1;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [INDEX_WIDTH-1:0] r_sweep_cnt;
  logic [INDEX_WIDTH-1:0] r_upd_idx;
  logic                   r_upd_taken;
  logic [INDEX_WIDTH-1:0] r_pend_idx;
  logic [1:0]             r_pend_val;
  logic                   r_pred_valid;
  logic [INDEX_WIDTH-1:0] r_pred_idx;

  logic [INDEX_WIDTH-1:0] w_lkup_idx;
  logic [INDEX_WIDTH-1:0] w_upd_idx;
  logic                   w_lkup_fire;
  logic                   w_upd_fire;
  logic                   w_sweep_last;
  logic                   w_fwd;
  logic [1:0]             w_sat_val;
  logic                   w_unused;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  assign w_lkup_idx   = lkup_pc[INDEX_WIDTH+1:2];
  assign w_upd_idx    = upd_pc[INDEX_WIDTH+1:2];
  assign w_sweep_last = &r_sweep_cnt;
  assign w_unused     = ^{lkup_pc[31:INDEX_WIDTH+2], lkup_pc[1:0],
                          upd_pc[31:INDEX_WIDTH+2], upd_pc[1:0]};

  // Reset is folded into the handshake outputs so nothing is accepted while rst_n is low.
  assign init_done   = rst_n && (r_state inside {ST_IDLE, ST_READ, ST_WRITE, ST_COMMIT});
  assign lkup_rdy    = init_done;
  assign upd_rdy     = rst_n && (r_state == ST_IDLE);
  assign w_lkup_fire = lkup_valid && lkup_rdy;
  assign w_upd_fire  = upd_valid && upd_rdy;

  assign w_sat_val = sat_ctr(sram_dout1, r_upd_taken);

  // A read issued during READ or WRITE misses the in-flight write; hand it the pending value.
  assign w_fwd = r_pred_valid && (r_state inside {ST_WRITE, ST_COMMIT}) &&
                 (r_pred_idx == r_pend_idx);

  assign pred_valid = rst_n && r_pred_valid;
  assign pred_ctr   = !pred_valid ? 2'b00 : (w_fwd ? r_pend_val : sram_dout0);
  assign pred_taken = pred_ctr[1];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next_state;
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:   if (w_sweep_last) w_next_state = ST_DRAIN;
      ST_DRAIN:  w_next_state = ST_IDLE;
      ST_IDLE:   if (w_upd_fire) w_next_state = ST_READ;
      ST_READ:   w_next_state = ST_WRITE;
      ST_WRITE:  w_next_state = ST_COMMIT;
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_INIT;
    endcase
  end

  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = 2'b00;
    sram_csb1  = 1'b1;
    sram_web1  = 1'b1;
    sram_addr1 = '0;
    sram_din1  = 2'b00;
    if (rst_n) begin
      if (w_lkup_fire) begin
        sram_csb0  = 1'b0;
        sram_addr0 = w_lkup_idx;
      end
      case (r_state)
        ST_INIT: begin
          sram_csb1  = 1'b0;
          sram_web1  = 1'b0;
          sram_addr1 = r_sweep_cnt;
          sram_din1  = INIT_CTR;
        end
        ST_IDLE: begin
          if (w_upd_fire) begin
            sram_csb1  = 1'b0;
            sram_addr1 = w_upd_idx;
          end
        end
        ST_READ: begin
          sram_csb1  = 1'b0;
          sram_web1  = 1'b0;
          sram_addr1 = r_upd_idx;
          sram_din1  = w_sat_val;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sweep_cnt  <= '0;
      r_upd_idx    <= '0;
      r_upd_taken  <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_val   <= 2'b00;
      r_pred_valid <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      if (r_state == ST_INIT) r_sweep_cnt <= r_sweep_cnt + IDX_ONE;
      r_pred_valid <= w_lkup_fire;
      if (w_lkup_fire) r_pred_idx <= w_lkup_idx;
      if (w_upd_fire) begin
        r_upd_idx   <= w_upd_idx;
        r_upd_taken <= upd_taken;
      end
      if (r_state == ST_READ) begin
        r_pend_idx <= r_upd_idx;
        r_pend_val <= w_sat_val;
      end
    end
  end

endmodule

// File: doc/bp_table_ctrl.md
BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 8, table index width (256 entries).
REQ-002 SHALL have parameter INIT_CTR, default 2'b01, counter value written by the init sweep.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port lkup_valid/lkup_rdy  input/output  1/1  lookup handshake.
REQ-006 SHALL have port lkup_pc  input  32  lookup PC; index = lkup_pc[INDEX_WIDTH+1:2].
REQ-007 SHALL have port pred_valid/pred_taken  output  1/1  prediction strobe and direction.
REQ-008 SHALL have port pred_ctr  output  2  raw counter value for the prediction.
REQ-009 SHALL have port upd_valid/upd_rdy  input/output  1/1  update handshake.
REQ-010 SHALL have port upd_pc/upd_taken  input  32/1  resolved branch PC and outcome; same index rule as lkup_pc.
REQ-011 SHALL have port init_done  output  1  table initialised.
REQ-012 SHALL have ports sram_csb0, sram_web0, sram_addr0[INDEX_WIDTH], sram_din0[2]  output  SRAM port 0 (lookup, read-only).
REQ-013 SHALL have port sram_dout0  input  2  SRAM port 0 read data.
REQ-014 SHALL have ports sram_csb1, sram_web1, sram_addr1[INDEX_WIDTH], sram_din1[2]  output  SRAM port 1 (init/update).
REQ-015 SHALL have port sram_dout1  input  2  SRAM port 1 read data.

Function
REQ-016 SHALL treat the SRAM as follows: address/control captured at a clock edge; dout valid in the following cycle; a write captured at edge E commits to the array at edge E+1.
REQ-017 SHALL drive SRAM port outputs combinationally from registered state plus the current-cycle handshake inputs.
REQ-018 SHALL tie sram_web0=1 and sram_din0=0.
REQ-019 SHALL run the init sweep: cycle k after reset release (k=0..255) drive csb1=0, web1=0, addr1=k, din1=INIT_CTR; cycle 256 drain; init_done=1 from cycle 257.
REQ-020 SHALL hold lkup_rdy=0, upd_rdy=0 and csb0=1 until init_done=1.
REQ-021 SHALL set lkup_rdy=init_done and accept one lookup per cycle; on accept drive csb0=0, addr0=index.
REQ-022 SHALL assert pred_valid exactly one cycle after accept, with pred_ctr=sram_dout0 (or forwarded value, REQ-026) and pred_taken=pred_ctr[1].
REQ-023 SHALL run the update FSM IDLE->READ->WRITE->COMMIT->IDLE: IDLE with upd_valid&&upd_rdy drives csb1=0, web1=1, addr1=index and latches index/taken; READ drives csb1=0, web1=0, addr1=latched index, din1=sat(sram_dout1); COMMIT drives csb1=1; upd_rdy=1 only in IDLE with init_done=1.
REQ-024 SHALL compute sat: taken -> min(ctr+1,3); not taken -> max(ctr-1,0); no 2-bit wrap.
REQ-025 SHALL register the written value in READ as pend_val/pend_idx, valid during WRITE and COMMIT states.
REQ-026 SHALL, when pred_valid is asserted while update FSM is in WRITE or COMMIT and the prediction index equals pend_idx, output pend_val instead of sram_dout0.
REQ-027 SHALL accept lookup and update in the same cycle independently, including the same index (lookup returns the pre-update value unless REQ-026 applies).
REQ-028 SHALL give sustained update throughput of one per 4 cycles; back-to-back updates to the same index SHALL each see the previous update's committed value.

Reset
REQ-029 SHALL, while rst_n=0, hold csb0=csb1=1, web0=web1=1, addr0=addr1=0, din1=0, pred_valid=0, pred_taken=0, pred_ctr=0, lkup_rdy=0, upd_rdy=0, init_done=0, FSM=INIT, sweep counter=0.
REQ-030 SHALL, on reset asserted mid-update or mid-sweep, discard in-flight work and restart the full sweep from index 0 after release.

Verification
REQ-031 SHALL verify init: release reset -> 256 writes of 2'b01 to addr 0..255 in order, init_done rises cycle 257, lookup of any index then returns ctr=1, taken=0.
REQ-032 SHALL verify saturation: three taken updates to index 5 -> counter 1->2->3->3; then four not-taken -> 2,1,0,0; no wrap.
REQ-033 SHALL verify forwarding: update taken on index 9 (ctr 1), lookup index 9 so pred_valid falls in WRITE or COMMIT -> pred_ctr=2, pred_taken=1.
REQ-034 SHALL verify concurrency: lookup index 3 and update index 3 accepted same cycle -> pred_ctr=1; next lookup after COMMIT -> 2.
REQ-035 SHALL verify back-pressure: upd_valid held high for 8 consecutive updates -> upd_rdy high 1 of every 4 cycles, all 8 applied in order.
REQ-036 SHALL verify reset mid-sweep: rst_n low at sweep index 100 for 2 cycles -> sweep restarts at addr 0, init_done only after 257 cycles.
